instr_fetch_ctrl: RTL

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ctrl
// Description : Instruction fetch controller. Holds a 16-bit wide program
//               memory that is loaded while the controller is idle. On start
//               it issues words from address 0 to the processor, one per
//               unstalled cycle, and follows jumps. It stops after issuing
//               a word whose opcode (bits 15:11) equals HALT_OP.
// Options     : `define IFC_ISSUE_CNT_EN adds the saturating issue counter.
//               Without it, issue_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
   parameter int         ADDR_W  = 8,
   parameter logic [4:0] HALT_OP = 5'h1F
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [15:0]       load_data,
   input  logic              start,
   input  logic              stall,
   input  logic              jmp_en,
   input  logic [ADDR_W-1:0] jmp_addr,
   output logic [15:0]       instr_out,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              done,
   output logic [15:0]       issue_cnt
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [15:0]       instr_q;
   logic              valid_q;
   logic              busy_q;
   logic              done_q;

   // Program memory. It has no reset, so its contents survive sys_rst.
   logic [15:0]       mem_q [DEPTH];

   logic [15:0]       rd_word;
   logic              issue;
   logic              launch;
   logic              halt_hit;

   assign rd_word  = mem_q[pc_q];
   assign issue    = (state_q == S_RUN) && !stall;
   // A start pulse that also carries a load is treated as a load only.
   assign launch   = (state_q != S_RUN) && start && !load_we;
   assign halt_hit = (rd_word[15:11] == HALT_OP);

   // Next fetch address. A jump is taken only on a non-halting issue.
   always_comb begin
      pc_d = pc_q + PC_ONE;
      if (jmp_en && !halt_hit) begin
         pc_d = jmp_addr;
      end
   end

   // Program load port. Writes are accepted only while the controller is not running.
   always_ff @(posedge clk) begin
      if (load_we && (state_q != S_RUN)) begin
         mem_q[load_addr] <= load_data;
      end
   end

   // Control FSM with registered issue outputs.
   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (issue) begin
                  instr_q <= rd_word;
                  valid_q <= 1'b1;
                  pc_q    <= pc_d;
                  if (halt_hit) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end else begin
                  valid_q <= 1'b0;
               end
            end
            default: begin
               // IDLE and DONE behave the same way. Both wait for a clean start.
               valid_q <= 1'b0;
               if (launch) begin
                  state_q <= S_RUN;
                  pc_q    <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign instr_out   = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign busy        = busy_q;
   assign done        = done_q;

`ifdef IFC_ISSUE_CNT_EN
   logic [15:0] cnt_q;

   // Issued-instruction counter. It clears on each launch and saturates at all-ones.
   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
         cnt_q <= '0;
      end else if (launch) begin
         cnt_q <= '0;
      end else if (issue && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign issue_cnt = cnt_q;
`else
   assign issue_cnt = '0;
`endif

endmodule
`default_nettype wire
